// File: rtl/elevator_pkg.sv
// Shared definitions for the single-car SCAN elevator scheduler.
// Contents: controller state enum, floor count/width constants, wr_data
// field positions, and helpers that build the above/below call masks and
// the register-file clear word.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 8;
  localparam int unsigned FLOOR_W    = 3;

  // wr_data layout: {call, dir, floor[2:0]}
  localparam int unsigned WR_DATA_W = 5;
  localparam int unsigned CALL_BIT  = 4;
  localparam int unsigned DIR_BIT   = 3;
  localparam int unsigned FLOOR_LSB = 0;

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    ARRIVE,
    SERVE,
    DOOR
  } state_t;

  // Bit i set for every floor strictly above 'floor'.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] floor);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (i > 32'(floor));
    end
    return m;
  endfunction

  // Bit i set for every floor strictly below 'floor'.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] floor);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      m[i] = (i < 32'(floor));
    end
    return m;
  endfunction

  // Register-file word that clears the call at 'floor'.
  function automatic logic [WR_DATA_W-1:0] clear_word(input logic [FLOOR_W-1:0] floor);
    logic [WR_DATA_W-1:0] w;
    w                        = '0;
    w[CALL_BIT]              = 1'b0;
    w[DIR_BIT]               = 1'b0;
    w[FLOOR_LSB +: FLOOR_W]  = floor;
    return w;
  endfunction

endpackage

// File: rtl/elevator_scheduler_timer.sv
// elev_timer: loadable down-counter shared by travel and door dwell timing.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (count -> 0)
//   load        - load load_value at the next edge (wins over counting)
//   load_value  - value to load
//   zero        - count is zero
// The counter holds at zero once it gets there.
module elev_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: single-car SCAN controller. Reads the per-floor call
// bits, picks a travel direction, steps the car floor by floor, opens the
// door for a fixed dwell and clears each served call in the register file.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   call_mask    - pending call per floor (bit i = floor i)
//   wr_en        - one-cycle register-file write strobe (SERVE only)
//   wr_regnum    - floor register being written
//   wr_data      - {call, dir, floor}; always the clear word here
//   cur_floor    - floor the car is at / last passed
//   motor_up/motor_down - drive car up / down (never both)
//   door_open    - door open
//   dir_up       - current scan direction, 1 = up
//   busy         - controller not idle
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_mask,
  output logic                  wr_en,
  output logic [FLOOR_W-1:0]    wr_regnum,
  output logic [WR_DATA_W-1:0]  wr_data,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic                  dir_up,
  output logic                  busy
);

  localparam int unsigned MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  state_t               state;
  state_t               decision;
  logic                 above;
  logic                 below;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_value;
  logic                 timer_zero;

  // SCAN decision shared by IDLE and ARRIVE: serve here, keep direction if
  // calls remain ahead, otherwise reverse.
  always_comb begin
    above    = |(call_mask & above_mask(cur_floor));
    below    = |(call_mask & below_mask(cur_floor));
    decision = IDLE;
    if (call_mask[cur_floor])  decision = SERVE;
    else if (dir_up && above)  decision = MOVE_UP;
    else if (!dir_up && below) decision = MOVE_DOWN;
    else if (above)            decision = MOVE_UP;
    else if (below)            decision = MOVE_DOWN;
  end

  // The timer is loaded on the edge that enters MOVE_* or DOOR, so its
  // load strobe is derived from the current state and the pending decision.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE, ARRIVE: begin
        if (decision == MOVE_UP || decision == MOVE_DOWN) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(TRAVEL_CYCLES - 1);
        end
      end
      SERVE: begin
        timer_load  = 1'b1;
        timer_value = TIMER_W'(DOOR_CYCLES - 1);
      end
      default: ;
    endcase
  end

  elev_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // Outputs are registered as a function of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_floor  <= '0;
      dir_up     <= 1'b1;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door_open  <= 1'b0;
      wr_en      <= 1'b0;
      wr_regnum  <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, ARRIVE: begin
          assert (!(decision == MOVE_UP && cur_floor == TOP_FLOOR));
          assert (!(decision == MOVE_DOWN && cur_floor == '0));
          state      <= decision;
          motor_up   <= (decision == MOVE_UP);
          motor_down <= (decision == MOVE_DOWN);
          door_open  <= 1'b0;
          if (decision == MOVE_UP)   dir_up <= 1'b1;
          if (decision == MOVE_DOWN) dir_up <= 1'b0;
          if (decision == SERVE) begin
            wr_en     <= 1'b1;
            wr_regnum <= cur_floor;
            wr_data   <= clear_word(cur_floor);
          end
        end
        MOVE_UP: begin
          if (timer_zero) begin
            if (cur_floor != TOP_FLOOR) cur_floor <= cur_floor + FLOOR_W'(1);
            motor_up <= 1'b0;
            state    <= ARRIVE;
          end
        end
        MOVE_DOWN: begin
          if (timer_zero) begin
            if (cur_floor != '0) cur_floor <= cur_floor - FLOOR_W'(1);
            motor_down <= 1'b0;
            state      <= ARRIVE;
          end
        end
        SERVE: begin
          door_open <= 1'b1;
          state     <= DOOR;
        end
        DOOR: begin
          // A fresh call here re-serves with the door held open; the dwell
          // restarts when SERVE reloads the timer.
          if (call_mask[cur_floor]) begin
            state     <= SERVE;
            wr_en     <= 1'b1;
            wr_regnum <= cur_floor;
            wr_data   <= clear_word(cur_floor);
          end else if (timer_zero) begin
            state     <= IDLE;
            door_open <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      assert (!(motor_up && motor_down));
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler (TRAVEL_CYCLES=4, DOOR_CYCLES=6).
// The bench owns the call register file: a wr_en pulse writes wr_data's call
// bit into call_mask. Expected serve order and timing come from a SCAN model
// that picks the nearest call in the travel direction and costs each trip
// arithmetically.
module tb_elevator_scheduler;

  localparam int T = 4;
  localparam int D = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] call_mask = '0;
  logic       wr_en;
  logic [2:0] wr_regnum;
  logic [4:0] wr_data;
  logic [2:0] cur_floor;
  logic       motor_up, motor_down, door_open, dir_up, busy;

  elevator_scheduler #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .call_mask  (call_mask),
    .wr_en      (wr_en),
    .wr_regnum  (wr_regnum),
    .wr_data    (wr_data),
    .cur_floor  (cur_floor),
    .motor_up   (motor_up),
    .motor_down (motor_down),
    .door_open  (door_open),
    .dir_up     (dir_up),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int t_idx, n_up, n_down, n_door, n_busy;
  int serve_q[$], time_q[$], data_q[$];
  int exp_floor_q[$], exp_time_q[$];
  int exp_up, exp_dn;
  int m_floor;
  bit m_dir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    t_idx = 0; n_up = 0; n_down = 0; n_door = 0; n_busy = 0;
    serve_q.delete(); time_q.delete(); data_q.delete();
  endtask

  // One clock; observe at the falling edge and act as the register file.
  task automatic tick();
    @(negedge clk);
    t_idx++;
    if (motor_up)   n_up++;
    if (motor_down) n_down++;
    if (door_open)  n_door++;
    if (busy)       n_busy++;
    check("motor_exclusive", 32'(motor_up & motor_down), 32'd0);
    if (wr_en) begin
      serve_q.push_back(int'(wr_regnum));
      time_q.push_back(t_idx);
      data_q.push_back(int'(wr_data));
      call_mask[wr_regnum] = wr_data[4];
    end
  endtask

  task automatic run_until_quiet(input int budget);
    int n = 0;
    while (!(busy == 1'b0 && call_mask == 8'h00) && n < budget) begin
      tick();
      n++;
    end
    check("quiet_within_budget", 32'(busy == 1'b0 && call_mask == 8'h00), 32'd1);
  endtask

  // SCAN reference: serve here, else nearest call ahead in the current
  // direction, else nearest call the other way. Trip of k floors costs
  // k*(T+1)+1 cycles to the clear pulse; a service then takes D+1 cycles
  // before the next decision.
  task automatic model_schedule(input logic [7:0] m_in);
    logic [7:0] m;
    int  f, tgt, k, decide, serve_t;
    bit  d, up_any, dn_any, go_up;
    m = m_in; f = m_floor; d = m_dir; decide = 0;
    exp_floor_q.delete(); exp_time_q.delete(); exp_up = 0; exp_dn = 0;
    while (m != 8'h00) begin
      up_any = 1'b0; dn_any = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (m[i] && i > f) up_any = 1'b1;
        if (m[i] && i < f) dn_any = 1'b1;
      end
      tgt = f;
      if (!m[f]) begin
        go_up = up_any && (d || !dn_any);
        if (go_up) begin
          d = 1'b1;
          for (int i = 7; i > f; i--) if (m[i]) tgt = i;
        end else begin
          d = 1'b0;
          for (int i = 0; i < f; i++) if (m[i]) tgt = i;
        end
      end
      k = (tgt > f) ? tgt - f : f - tgt;
      if (tgt > f) exp_up += k * T; else exp_dn += k * T;
      serve_t = decide + k * (T + 1) + 1;
      exp_floor_q.push_back(tgt);
      exp_time_q.push_back(serve_t);
      decide = serve_t + D + 1;
      m[tgt] = 1'b0;
      f = tgt;
    end
    m_floor = f;
    m_dir = d;
  endtask

  task automatic compare_to_model(input string tag);
    check({tag, "_serve_count"}, 32'(serve_q.size()), 32'(exp_floor_q.size()));
    for (int i = 0; i < exp_floor_q.size(); i++) begin
      if (i < serve_q.size()) begin
        check({tag, "_serve_floor"}, 32'(serve_q[i]), 32'(exp_floor_q[i]));
        check({tag, "_serve_time"},  32'(time_q[i]),  32'(exp_time_q[i]));
        check({tag, "_wr_data"},     32'(data_q[i]),  32'(exp_floor_q[i]));
      end
    end
    check({tag, "_up_cycles"},   32'(n_up),      32'(exp_up));
    check({tag, "_down_cycles"}, 32'(n_down),    32'(exp_dn));
    check({tag, "_end_floor"},   32'(cur_floor), 32'(m_floor));
    check({tag, "_end_dir"},     32'(dir_up),    32'(m_dir));
  endtask

  initial begin
    int n;
    logic [7:0] mask;

    // Reset state
    clear_stats();
    reset = 1'b1;
    tick(); tick();
    check("rst_cur_floor",  32'(cur_floor),  32'd0);
    check("rst_dir_up",     32'(dir_up),     32'd1);
    check("rst_motor_up",   32'(motor_up),   32'd0);
    check("rst_motor_down", 32'(motor_down), 32'd0);
    check("rst_door_open",  32'(door_open),  32'd0);
    check("rst_wr_en",      32'(wr_en),      32'd0);
    check("rst_wr_regnum",  32'(wr_regnum),  32'd0);
    check("rst_wr_data",    32'(wr_data),    32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    reset = 1'b0;
    m_floor = 0; m_dir = 1'b1;

    // 1: call at the current floor
    clear_stats();
    model_schedule(8'h01);
    call_mask = 8'h01;
    tick();
    check("t1_wr_en",     32'(wr_en),     32'd1);
    check("t1_wr_regnum", 32'(wr_regnum), 32'd0);
    check("t1_wr_data",   32'(wr_data),   32'h00);
    check("t1_door_in_serve", 32'(door_open), 32'd0);
    run_until_quiet(50);
    check("t1_door_cycles", 32'(n_door), 32'd6);
    check("t1_idle_tick",   32'(t_idx),  32'd8);
    compare_to_model("t1");

    // 2: call four floors up
    clear_stats();
    model_schedule(8'h10);
    call_mask = 8'h10;
    run_until_quiet(200);
    check("t2_up_cycles", 32'(n_up),      32'd16);
    check("t2_floor",     32'(cur_floor), 32'd4);
    check("t2_dir_up",    32'(dir_up),    32'd1);
    if (serve_q.size() > 0) begin
      check("t2_wr_regnum", 32'(serve_q[0]), 32'd4);
      check("t2_wr_data",   32'(data_q[0]),  32'h04);
      check("t2_latency",   32'(time_q[0]),  32'd21);
    end
    compare_to_model("t2");

    // 3: calls above and below while heading up
    clear_stats();
    model_schedule(8'h41);
    call_mask = 8'h41;
    run_until_quiet(300);
    check("t3_down_cycles", 32'(n_down),    32'd24);
    check("t3_up_cycles",   32'(n_up),      32'd8);
    check("t3_dir_up",      32'(dir_up),    32'd0);
    check("t3_floor",       32'(cur_floor), 32'd0);
    if (serve_q.size() == 2) begin
      check("t3_first",  32'(serve_q[0]), 32'd6);
      check("t3_second", 32'(serve_q[1]), 32'd0);
      check("t3_second_time", 32'(time_q[1]), 32'd49);
    end
    compare_to_model("t3");

    // 4: repeat call at the top floor during the door dwell
    clear_stats();
    model_schedule(8'h80);
    call_mask = 8'h80;
    n = 0;
    while (!wr_en && n < 100) begin tick(); n++; end
    check("t4_reach_top", 32'(wr_en),     32'd1);
    check("t4_latency",   32'(t_idx),     32'd36);
    check("t4_regnum",    32'(wr_regnum), 32'd7);
    clear_stats();
    tick(); tick(); tick();
    check("t4_door_c3", 32'(door_open), 32'd1);
    call_mask[7] = 1'b1;
    tick();
    check("t4_reserve_wr_en", 32'(wr_en),     32'd1);
    check("t4_reserve_reg",   32'(wr_regnum), 32'd7);
    check("t4_reserve_data",  32'(wr_data),   32'h07);
    check("t4_reserve_door",  32'(door_open), 32'd1);
    run_until_quiet(100);
    check("t4_door_cycles", 32'(n_door),         32'd10);
    check("t4_idle_tick",   32'(t_idx),          32'd11);
    check("t4_pulses",      32'(serve_q.size()), 32'd1);
    check("t4_no_motor_up", 32'(n_up),           32'd0);

    // 5: reset mid-travel
    clear_stats();
    model_schedule(8'h04);
    call_mask = 8'h04;
    run_until_quiet(200);
    compare_to_model("t5_pre");
    call_mask = 8'h08;
    tick();
    check("t5_move_c1", 32'(motor_up), 32'd1);
    tick();
    check("t5_move_c2", 32'(motor_up), 32'd1);
    reset = 1'b1;
    tick();
    check("t5_floor",      32'(cur_floor),  32'd0);
    check("t5_motor_up",   32'(motor_up),   32'd0);
    check("t5_motor_down", 32'(motor_down), 32'd0);
    check("t5_door",       32'(door_open),  32'd0);
    check("t5_wr_en",      32'(wr_en),      32'd0);
    check("t5_wr_regnum",  32'(wr_regnum),  32'd0);
    check("t5_wr_data",    32'(wr_data),    32'd0);
    check("t5_busy",       32'(busy),       32'd0);
    check("t5_dir",        32'(dir_up),     32'd1);
    reset = 1'b0;
    call_mask = 8'h00;
    m_floor = 0; m_dir = 1'b1;

    // 6: no calls
    clear_stats();
    repeat (100) tick();
    check("t6_busy",   32'(n_busy),         32'd0);
    check("t6_up",     32'(n_up),           32'd0);
    check("t6_down",   32'(n_down),         32'd0);
    check("t6_door",   32'(n_door),         32'd0);
    check("t6_wr",     32'(serve_q.size()), 32'd0);

    // Random call patterns against the SCAN model
    for (int r = 0; r < 25; r++) begin
      clear_stats();
      mask = 8'($urandom_range(1, 255));
      model_schedule(mask);
      call_mask = mask;
      run_until_quiet(1500);
      compare_to_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
